mcu_sequencer: RTL and testbench

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

---
 rtl/mcu_pkg.sv | 23 ++
 rtl/mcu_song_counter.sv | 56 +++++
 rtl/mcu_sequencer.sv | 106 ++++++++++
 tb/tb_mcu_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types and defaults for the MCU song sequencer.
// The sequencer FSM state enum and the default song-count constants live here
// so the top level and the song counter agree on them.
package mcu_pkg;

    // Default number of selectable songs and the matching index width.
    localparam int DEF_NUM_SONGS = 4;
    localparam int DEF_SONG_W    = 2;

    // Sequencer states. CHANGE is a one-cycle rewind step between two
    // stable states; the state to return to is held separately.
    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        CHANGE  = 2'd2
    } state_e;

    // True when an index of the given width can address every song.
    function automatic bit song_w_fits(input int num_songs, input int song_w);
        return (2 ** song_w) >= num_songs;
    endfunction

endpackage

// File: rtl/mcu_song_counter.sv
// Wrapping up/down song index.
// inc steps the index forward and wraps NUM_SONGS-1 -> 0; dec steps it back and
// wraps 0 -> NUM_SONGS-1. inc wins if both are asserted. The index never
// leaves 0..NUM_SONGS-1, including for non-power-of-two song counts.
module mcu_song_counter
    import mcu_pkg::*;
#(
    parameter int NUM_SONGS = DEF_NUM_SONGS,
    parameter int SONG_W    = DEF_SONG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [SONG_W-1:0] idx
);

    // Reject configurations whose index cannot hold every song.
    if (!song_w_fits(NUM_SONGS, SONG_W)) begin : g_bad_width
        $error("mcu_song_counter: 2**SONG_W must be >= NUM_SONGS");
    end
    if (NUM_SONGS < 2 || NUM_SONGS > 256) begin : g_bad_count
        $error("mcu_song_counter: NUM_SONGS must be in 2..256");
    end

    localparam logic [SONG_W-1:0] LAST_IDX = SONG_W'(NUM_SONGS - 1);
    localparam logic [SONG_W-1:0] ONE      = SONG_W'(1);

    logic [SONG_W-1:0] idx_q;
    logic [SONG_W-1:0] idx_d;

    // Next index: explicit compare against the last song gives the wrap
    // for any song count, not just powers of two.
    always_comb begin
        // NOTE: default assigned first so no path leaves idx_d unassigned (no latch).
        idx_d = idx_q;
        if (inc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ONE;
        end else if (dec) begin
            idx_d = (idx_q == '0) ? LAST_IDX : idx_q - ONE;
        end
    end

    // Index register with synchronous active-low reset to song 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/mcu_sequencer.sv
// MCU song sequencer: play/pause control and song selection for a song player.
// States PAUSED and PLAYING are stable; any song change (or end of song) passes
// through a single CHANGE cycle that pulses reset_player to rewind the player,
// then returns to the recorded state. Inputs arriving in CHANGE are dropped.
// Input priority: next_button > prev_button > song_done > play_button.
// Optional feature: define MCU_AUTO_ADVANCE_EN to make song_done in PLAYING
// advance to the next song and keep playing; without it song_done rewinds the
// current song and stops.
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int NUM_SONGS = DEF_NUM_SONGS,
    parameter int SONG_W    = DEF_SONG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song
);

    state_e state_q, state_d;
    state_e ret_q, ret_d;
    logic   play_q, play_d;
    logic   reset_player_q, reset_player_d;
    logic   song_inc;
    logic   song_dec;

    // Next-state logic, song step requests and next output values.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        song_inc = 1'b0;
        song_dec = 1'b0;

        unique case (state_q)
            CHANGE: begin
                // Single rewind cycle; everything sampled here is dropped.
                state_d = ret_q;
            end
            PAUSED, PLAYING: begin
                if (next_button) begin
                    song_inc = 1'b1;
                    ret_d    = state_q;
                    state_d  = CHANGE;
                end else if (prev_button) begin
                    song_dec = 1'b1;
                    ret_d    = state_q;
                    state_d  = CHANGE;
                end else if (song_done && state_q == PLAYING) begin
                    state_d = CHANGE;
`ifdef MCU_AUTO_ADVANCE_EN
                    song_inc = 1'b1;
                    ret_d    = PLAYING;
`else
                    ret_d    = PAUSED;
`endif
                end else if (play_button) begin
                    state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
                end
            end
            default: begin
                state_d = PAUSED;
            end
        endcase

        // Outputs are registered copies of what the next state implies, so
        // they line up with the state register after the same edge.
        play_d         = (state_d == PLAYING);
        reset_player_d = (state_d == CHANGE);
    end

    // State, return state and registered outputs; reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= PAUSED;
            ret_q          <= PAUSED;
            play_q         <= 1'b0;
            reset_player_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            play_q         <= play_d;
            reset_player_q <= reset_player_d;
        end
    end

    mcu_song_counter #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_W    (SONG_W)
    ) u_song_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (song_inc),
        .dec   (song_dec),
        .idx   (song)
    );

    assign play         = play_q;
    assign reset_player = reset_player_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Testbench for mcu_sequencer with NUM_SONGS=3.
// A behavioural model (song number plus playing/rewinding flags) predicts the
// outputs; a negedge process compares every cycle, and directed sequences add
// hand-computed literal expectations before a long randomized run.
module tb_mcu_sequencer;

    localparam int N = 3;
    localparam int W = 2;
`ifdef MCU_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         play_button = 1'b0;
    logic         next_button = 1'b0;
    logic         prev_button = 1'b0;
    logic         song_done = 1'b0;
    logic         play;
    logic         reset_player;
    logic [W-1:0] song;

    int total = 0;
    int bad   = 0;

    // Model state.
    int m_song     = 0;
    bit m_playing  = 1'b0;  // player runs (or will resume after rewind)
    bit m_rewind   = 1'b0;  // in the one-cycle rewind step
    bit m_ret_play = 1'b0;  // playing after the rewind step
    bit m_valid    = 1'b0;  // outputs defined (a reset edge has been seen)

    mcu_sequencer #(
        .NUM_SONGS (N),
        .SONG_W    (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .play_button  (play_button),
        .next_button  (next_button),
        .prev_button  (prev_button),
        .song_done    (song_done),
        .play         (play),
        .reset_player (reset_player),
        .song         (song)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the sampled inputs.
    task automatic model_step(input bit r, input bit nb, input bit pb, input bit dn, input bit pl);
        if (!r) begin
            m_song    = 0;
            m_playing = 1'b0;
            m_rewind  = 1'b0;
            m_valid   = 1'b1;
        end else if (m_rewind) begin
            m_rewind  = 1'b0;
            m_playing = m_ret_play;
        end else if (nb) begin
            m_song     = (m_song + 1) % N;
            m_ret_play = m_playing;
            m_rewind   = 1'b1;
        end else if (pb) begin
            m_song     = (m_song + N - 1) % N;
            m_ret_play = m_playing;
            m_rewind   = 1'b1;
        end else if (dn && m_playing) begin
            if (AUTO) m_song = (m_song + 1) % N;
            m_ret_play = AUTO;
            m_rewind   = 1'b1;
        end else if (pl) begin
            m_playing = !m_playing;
        end
    endtask

    // Apply inputs for one cycle; outputs are settled 1 time unit after the edge.
    task automatic cycle(input bit r, input bit nb, input bit pb, input bit dn, input bit pl);
        reset       = r;
        next_button = nb;
        prev_button = pb;
        song_done   = dn;
        play_button = pl;
        @(posedge clk);
        model_step(r, nb, pb, dn, pl);
        #1;
        reset       = 1'b1;
        next_button = 1'b0;
        prev_button = 1'b0;
        song_done   = 1'b0;
        play_button = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hand-computed expectation for all three outputs.
    task automatic lit(input string name, input int s, input bit pl, input bit rp);
        check({name, ".song"}, 32'(song), 32'(s));
        check({name, ".play"}, 32'(play), 32'(pl));
        check({name, ".reset_player"}, 32'(reset_player), 32'(rp));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model.song", 32'(song), 32'(m_song));
            check("model.play", 32'(play), 32'(m_playing && !m_rewind));
            check("model.reset_player", 32'(reset_player), 32'(m_rewind));
        end
    end

    initial begin
        int s0;

        // Reset held low for two cycles, then released.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("reset", 0, 1'b0, 1'b0);
        idle();
        lit("after_reset", 0, 1'b0, 1'b0);

        // Three next presses from PAUSED wrap 1, 2, 0 with one rewind each.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("next1", 1, 1'b0, 1'b1);
        idle();                              lit("next1_ret", 1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("next2", 2, 1'b0, 1'b1);
        idle();                              lit("next2_ret", 2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("next3", 0, 1'b0, 1'b1);
        idle();                              lit("next3_ret", 0, 1'b0, 1'b0);

        // Start playing: no rewind pulse.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); lit("play", 0, 1'b1, 1'b0);

        // prev from song 0 while playing wraps to 2, then resumes.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); lit("prev_wrap", 2, 1'b0, 1'b1);
        idle();                              lit("prev_ret", 2, 1'b1, 1'b0);

        // Move to song 1 while playing.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("to0", 0, 1'b0, 1'b1);
        idle();                              lit("to0_ret", 0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("to1", 1, 1'b0, 1'b1);
        idle();                              lit("to1_ret", 1, 1'b1, 1'b0);

        // End of song while playing.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        if (AUTO) begin
            lit("done_auto", 2, 1'b0, 1'b1);
            idle();
            lit("done_auto_ret", 2, 1'b1, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            lit("pause", 2, 1'b0, 1'b0);
            s0 = 2;
        end else begin
            lit("done_stop", 1, 1'b0, 1'b1);
            idle();
            lit("done_stop_ret", 1, 1'b0, 1'b0);
            s0 = 1;
        end

        // next and play together while paused: next wins, stays paused.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); lit("next_play", (s0 + 1) % N, 1'b0, 1'b1);
        idle();                              lit("next_play_ret", (s0 + 1) % N, 1'b0, 1'b0);

        // song_done ignored while paused.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); lit("done_paused", (s0 + 1) % N, 1'b0, 1'b0);

        // next during the rewind cycle is dropped.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("chg_enter", (s0 + 2) % N, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("chg_ignore", (s0 + 2) % N, 1'b0, 1'b0);

        // Reset during the rewind cycle overrides everything.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("chg_enter2", (s0 + 3) % N, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); lit("chg_reset", 0, 1'b0, 1'b0);
        idle();                              lit("chg_reset_ret", 0, 1'b0, 1'b0);

        // Randomized run, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) != 0,
                  $urandom_range(5) == 0,
                  $urandom_range(5) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(2) == 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
